// File: rtl/io_data.sv
// Bidirectional pad controller: direction FSM with tri-state turnaround cycles,
// registered transmit data, and a reset-cleared synchronizer on the receive path.
module io_data #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int TURNAROUND  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    inout  wire  [WIDTH-1:0] dinout,
    output logic             oe
);

    localparam logic [2:0] TA = 3'(TURNAROUND);

    typedef enum logic [1:0] {
        RX,
        TURN_TX,
        TX,
        TURN_RX
    } state_t;

    state_t           state, state_next;
    logic [2:0]       cnt, cnt_next;
    logic [WIDTH-1:0] din_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            RX: begin
                if (en) begin
                    if (TA == 3'd0) begin
                        state_next = TX;
                    end else begin
                        state_next = TURN_TX;
                        cnt_next   = TA;
                    end
                end
            end
            TURN_TX: begin
                // A dropped request aborts the turnaround before the pad is ever driven.
                if (!en) begin
                    state_next = RX;
                    cnt_next   = 3'd0;
                end else if (cnt <= 3'd1) begin
                    state_next = TX;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            TX: begin
                if (!en) begin
                    if (TA == 3'd0) begin
                        state_next = RX;
                    end else begin
                        state_next = TURN_RX;
                        cnt_next   = TA;
                    end
                end
            end
            TURN_RX: begin
                // Release always completes so the far end sees the full idle gap.
                if (cnt <= 3'd1) begin
                    state_next = RX;
                    cnt_next   = 3'd0;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            default: begin
                state_next = RX;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RX;
            cnt   <= 3'd0;
            oe    <= 1'b0;
            din_q <= '0;
            // NOTE: the synchronizer is a small flop chain, not a memory, so it is cleared on reset.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            oe        <= (state_next == TX);
            din_q     <= din;
            sync_q[0] <= dinout;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // oe is a flop output, so the pad enable cannot glitch with en.
    assign dinout = oe ? din_q : {WIDTH{1'bz}};
    assign dout   = sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_io_data.sv
// Directed bench for io_data: u0 (TURNAROUND=1) with an external pad driver and a
// dout scoreboard, u1 (TURNAROUND=2) sharing the controls to check its oe timing.
module tb_io_data;

    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n, en, din;
    logic dout0, dout1, oe0, oe1;
    wire  pad0, pad1;

    logic ext_on, ext_en, ext_val;
    assign pad0 = ext_en ? ext_val : 1'bz;

    io_data #(.WIDTH(1), .SYNC_STAGES(S), .TURNAROUND(1)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din),
        .dout(dout0), .dinout(pad0), .oe(oe0)
    );

    io_data #(.WIDTH(1), .SYNC_STAGES(S), .TURNAROUND(2)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .din(din),
        .dout(dout1), .dinout(pad1), .oe(oe1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit   vld;
        logic v;
    } samp_t;

    samp_t sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    logic  prev_oe  = 1'b0;
    logic  dinq_m   = 1'b0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: push the pad value u0 will sample, then check oe, pad and dout after the edge.
    task automatic tick(input logic exp_oe0, input logic exp_oe1, input string tag);
        samp_t s;
        ext_en = ext_on && !prev_oe && !exp_oe0;
        s.vld  = prev_oe || ext_en;
        s.v    = prev_oe ? dinq_m : ext_val;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            dinq_m = 1'b0;
            sb.delete();
            for (int i = 0; i < S - 1; i++) sb.push_back('{1'b1, 1'b0});
            chk({tag, ".dout_rst"}, dout0, 1'b0);
        end else begin
            dinq_m = din;
            sb.push_back(s);
            if (sb.size() >= S) begin
                s = sb.pop_front();
                if (s.vld) chk({tag, ".dout"}, dout0, s.v);
            end
        end
        chk({tag, ".oe0"}, oe0, exp_oe0);
        chk({tag, ".oe1"}, oe1, exp_oe1);
        if (exp_oe0) chk({tag, ".pad_tx"}, pad0, dinq_m);
        else if (ext_en) chk({tag, ".pad_rx"}, pad0, ext_val);
        prev_oe = exp_oe0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; din = 1'b0;
        ext_on = 1'b1; ext_en = 1'b0; ext_val = 1'b1;

        // Reset with external driver holding 1, then release.
        repeat (3) tick(0, 0, "reset");
        rst_n = 1'b1;
        repeat (4) tick(0, 0, "release");

        // Receive: dout follows the pad with a two-cycle lag.
        ext_val = 1'b0; repeat (4) tick(0, 0, "rx_fall");
        ext_val = 1'b1; repeat (3) tick(0, 0, "rx_rise");
        ext_val = 1'b0; repeat (3) tick(0, 0, "rx_fall2");

        // Turn to transmit, then drive a data pattern and watch loopback.
        en = 1'b1; din = 1'b1;
        tick(0, 0, "turn_tx");
        tick(1, 0, "tx_first");
        din = 1'b0; tick(1, 1, "tx_d0");
        din = 1'b1; tick(1, 1, "tx_d1");
        din = 1'b0; tick(1, 1, "tx_d2");
        tick(1, 1, "tx_hold");
        tick(1, 1, "tx_hold2");

        // Back to receive; external driver resumes after oe falls.
        en = 1'b0;
        tick(0, 0, "turn_rx");
        tick(0, 0, "rx_back");
        tick(0, 0, "rx_back2");
        ext_val = 1'b1; repeat (3) tick(0, 0, "rx_after_tx");

        // One-cycle en pulse aborts the turnaround.
        en = 1'b1; tick(0, 0, "pulse_hi");
        en = 1'b0; tick(0, 0, "pulse_abort");
        tick(0, 0, "pulse_idle");

        // TURN_RX ignores a re-raised en and then restarts the transmit turnaround.
        en = 1'b1;
        tick(0, 0, "f_tt");
        tick(1, 0, "f_tx0");
        tick(1, 1, "f_tx1");
        en = 1'b0; tick(0, 0, "f_tr");
        en = 1'b1; tick(0, 0, "f_tr_ignore");
        tick(0, 0, "f_restart");
        tick(1, 0, "f_tx2");
        tick(1, 0, "f_tx3");
        tick(1, 1, "f_tx4");

        // Reset in the middle of transmit releases the pad at once.
        din = 1'b1; tick(1, 1, "tx_pre_rst");
        rst_n = 1'b0; tick(0, 0, "rst_in_tx");
        tick(0, 0, "rst_hold");
        rst_n = 1'b1;
        tick(0, 0, "post_rst_tt");
        tick(1, 0, "post_rst_tx");
        tick(1, 1, "post_rst_tx1");
        en = 1'b0;
        repeat (3) tick(0, 0, "final_rx");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
